apb_rr_arbiter: RTL and testbench

APB_RR_ARBITER -- requirements
Module: apb_rr_arbiter

---
 rtl/apb_arb_pkg.sv | 21 ++
 rtl/apb_rr_pick.sv | 27 ++
 rtl/apb_rr_arbiter.sv | 144 ++++++++++++++
 tb/tb_apb_rr_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_arb_pkg.sv
// Shared types and sizes for the two-requester APB round-robin arbiter.
// Also holds the helper that advances the round-robin priority pointer.
package apb_arb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;
  localparam int NUM_REQ    = 2;
  localparam int PTR_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  // Priority passes to the requester after the one that just finished.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] owner);
    return (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + PTR_W'(1);
  endfunction

endpackage

// File: rtl/apb_rr_pick.sv
// Combinational round-robin pick: first requesting index at or after the priority pointer.
// Zero latency; vld_o low when nothing is requesting.
module apb_rr_pick
  import apb_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   prio_i,
  output logic               vld_o,
  output logic [PTR_W-1:0]   idx_o
);

  logic [PTR_W-1:0] cand;

  always_comb begin
    vld_o = 1'b0;
    idx_o = '0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = PTR_W'((int'(prio_i) + i) % NUM_REQ);
      if (!vld_o && req_i[cand]) begin
        vld_o = 1'b1;
        idx_o = cand;
      end
    end
  end

endmodule

// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter sharing one APB slave between two requesters; IDLE/SETUP/ACCESS FSM.
// Optional ACCESS-phase timeout with err_o when APB_ARB_TIMEOUT_EN is defined.
module apb_rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                                pclk,
  input  logic                                preset_n,
  input  logic [NUM_REQ-1:0]                  req_i,
  input  logic [NUM_REQ-1:0][APB_ADDR_W-1:0]  addr_i,
  input  logic [NUM_REQ-1:0]                  write_i,
  input  logic [NUM_REQ-1:0][APB_DATA_W-1:0]  wdata_i,
  output logic [NUM_REQ-1:0]                  gnt_o,
  output logic [NUM_REQ-1:0]                  done_o,
  output logic                                err_o,
  output logic [APB_DATA_W-1:0]               rdata_o,
  output logic                                psel_o,
  output logic                                penable_o,
  output logic                                pwrite_o,
  output logic [APB_ADDR_W-1:0]               paddr_o,
  output logic [APB_DATA_W-1:0]               pwdata_o,
  input  logic [APB_DATA_W-1:0]               prdata_i,
  input  logic                                pready_i
);

  state_e                  state_q;
  logic [PTR_W-1:0]        prio_q;
  logic [PTR_W-1:0]        owner_q;
  logic [NUM_REQ-1:0]      gnt_q;
  logic [NUM_REQ-1:0]      done_q;
  logic [APB_DATA_W-1:0]   rdata_q;
  logic                    psel_q;
  logic                    penable_q;
  logic                    pwrite_q;
  logic [APB_ADDR_W-1:0]   paddr_q;
  logic [APB_DATA_W-1:0]   pwdata_q;

  logic [NUM_REQ-1:0]      req_d;
  logic                    pick_vld;
  logic [PTR_W-1:0]        pick_idx;
  logic                    tmo_hit;

  // A requester sees done_o one cycle before it can drop req_i; mask it so it is not re-granted.
  assign req_d = req_i & ~done_q;

  apb_rr_pick u_pick (
    .req_i  (req_d),
    .prio_i (prio_q),
    .vld_o  (pick_vld),
    .idx_o  (pick_idx)
  );

`ifdef APB_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_q;
  logic             err_q;

  assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= (state_q == ACCESS) ? tmo_q + TMO_W'(1) : '0;
      err_q <= (state_q == ACCESS) && !pready_i && tmo_hit;
    end
  end

  assign err_o = err_q;
`else
  logic unused_tmo;

  assign unused_tmo = ^TIMEOUT_CYCLES;
  assign tmo_hit    = 1'b0;
  assign err_o      = 1'b0;
`endif

  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      state_q   <= IDLE;
      prio_q    <= '0;
      owner_q   <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      rdata_q   <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
    end else begin
      done_q <= '0;
      case (state_q)
        IDLE: begin
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
          if (pick_vld) begin
            state_q  <= SETUP;
            owner_q  <= pick_idx;
            gnt_q    <= NUM_REQ'(1) << pick_idx;
            psel_q   <= 1'b1;
            pwrite_q <= write_i[pick_idx];
            paddr_q  <= addr_i[pick_idx];
            pwdata_q <= wdata_i[pick_idx];
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (pready_i || tmo_hit) begin
            state_q   <= IDLE;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            gnt_q     <= '0;
            done_q    <= gnt_q;
            prio_q    <= next_ptr(owner_q);
            // A slave response wins over a timeout landing in the same cycle.
            if (!pready_i) begin
              rdata_q <= '0;
            end else if (!pwrite_q) begin
              rdata_q <= prdata_i;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt_o     = gnt_q;
  assign done_o    = done_q;
  assign rdata_o   = rdata_q;
  assign psel_o    = psel_q;
  assign penable_o = penable_q;
  assign pwrite_o  = pwrite_q;
  assign paddr_o   = paddr_q;
  assign pwdata_o  = pwdata_q;

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Scoreboard bench for apb_rr_arbiter: queue-level round-robin model plus a wait-state APB slave.
module tb_apb_rr_arbiter;
  import apb_arb_pkg::*;

  localparam logic [31:0] KEY = 32'h5A5A_0F0F;

  logic                               pclk = 1'b0;
  logic                               preset_n;
  logic [NUM_REQ-1:0]                 req_i;
  logic [NUM_REQ-1:0][APB_ADDR_W-1:0] addr_i;
  logic [NUM_REQ-1:0]                 write_i;
  logic [NUM_REQ-1:0][APB_DATA_W-1:0] wdata_i;
  logic [NUM_REQ-1:0]                 gnt_o;
  logic [NUM_REQ-1:0]                 done_o;
  logic                               err_o;
  logic [31:0]                        rdata_o;
  logic                               psel_o;
  logic                               penable_o;
  logic                               pwrite_o;
  logic [31:0]                        paddr_o;
  logic [31:0]                        pwdata_o;
  logic [31:0]                        prdata_i;
  logic                               pready_i;

  always #5 pclk = ~pclk;

  apb_rr_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .pclk      (pclk),
    .preset_n  (preset_n),
    .req_i     (req_i),
    .addr_i    (addr_i),
    .write_i   (write_i),
    .wdata_i   (wdata_i),
    .gnt_o     (gnt_o),
    .done_o    (done_o),
    .err_o     (err_o),
    .rdata_o   (rdata_o),
    .psel_o    (psel_o),
    .penable_o (penable_o),
    .pwrite_o  (pwrite_o),
    .paddr_o   (paddr_o),
    .pwdata_o  (pwdata_o),
    .prdata_i  (prdata_i),
    .pready_i  (pready_i)
  );

  typedef struct packed {
    logic [1:0]  done;
    logic [31:0] rdata;
    logic        err;
  } exp_done_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [1:0]  gnt;
  } exp_apb_t;

  exp_done_t   done_q[$];
  exp_apb_t    apb_q[$];
  int          passes = 0;
  int          total  = 0;
  int          wait_cfg = 0;
  bit          slave_dead = 1'b0;
  int          mdl_ptr = 0;
  logic [31:0] mdl_last_rd = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
  endtask

  // Slave: wait_cfg wait states per transfer, read data derived from the address.
  initial begin
    int wcnt;
    wcnt     = 0;
    pready_i = 1'b0;
    prdata_i = '0;
    forever begin
      @(posedge pclk);
      #2;
      if (psel_o && penable_o && !slave_dead) begin
        if (wcnt == 0) pready_i = 1'b1;
        else begin
          pready_i = 1'b0;
          wcnt--;
        end
      end else begin
        pready_i = 1'b0;
        wcnt     = wait_cfg;
      end
      prdata_i = paddr_o ^ KEY;
    end
  end

  // Monitor: pops expectations whenever the DUT completes a transfer.
  initial begin
    exp_done_t e;
    exp_apb_t  a;
    forever begin
      @(negedge pclk);
      if (preset_n === 1'b1) begin
        if (done_o != 2'b00) begin
          if (done_q.size() == 0) chk("unexpected_done", {30'd0, done_o}, 32'd0);
          else begin
            e = done_q.pop_front();
            chk("done_owner", {30'd0, done_o}, {30'd0, e.done});
            chk("done_rdata", rdata_o, e.rdata);
            chk("done_err", {31'd0, err_o}, {31'd0, e.err});
          end
        end
        if (psel_o && penable_o && pready_i) begin
          if (apb_q.size() == 0) chk("unexpected_apb", {31'd0, pready_i}, 32'd0);
          else begin
            a = apb_q.pop_front();
            chk("apb_addr", paddr_o, a.addr);
            chk("apb_write", {31'd0, pwrite_o}, {31'd0, a.wr});
            chk("apb_wdata", pwdata_o, a.wdata);
            chk("apb_gnt", {30'd0, gnt_o}, {30'd0, a.gnt});
          end
        end
      end
    end
  end

  task automatic flush_model();
    done_q.delete();
    apb_q.delete();
    mdl_ptr     = 0;
    mdl_last_rd = '0;
  endtask

  task automatic do_reset();
    preset_n = 1'b0;
    req_i    = '0;
    repeat (2) @(negedge pclk);
    preset_n = 1'b1;
    flush_model();
  endtask

  task automatic rand_payload();
    for (int k = 0; k < 2; k++) begin
      addr_i[k]  = $urandom;
      wdata_i[k] = $urandom;
      write_i[k] = 1'($urandom_range(0, 1));
    end
  endtask

  // Model: pending requesters are served starting at the pointer; the pointer then moves past the owner.
  task automatic issue(input logic [1:0] mask);
    int first;
    int o;
    first = mask[mdl_ptr] ? mdl_ptr : 1 - mdl_ptr;
    for (int n = 0; n < 2; n++) begin
      o = (n == 0) ? first : 1 - first;
      if (mask[o]) begin
        apb_q.push_back('{addr: addr_i[o], wr: write_i[o], wdata: wdata_i[o], gnt: 2'(1 << o)});
        if (!write_i[o]) mdl_last_rd = addr_i[o] ^ KEY;
        done_q.push_back('{done: 2'(1 << o), rdata: mdl_last_rd, err: 1'b0});
        mdl_ptr = 1 - o;
      end
    end
    req_i = mask;
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int n;
    n = 0;
    while (n < budget) begin
      @(negedge pclk);
      for (int k = 0; k < 2; k++) if (done_o[k]) req_i[k] = 1'b0;
      if (req_i == 2'b00 && !psel_o) break;
      n++;
    end
    chk({"idle_", nm}, 32'(n < budget), 32'd1);
    @(negedge pclk);
  endtask

  task automatic count_access(output int n, input int budget);
    n = 0;
    for (int c = 0; c < budget; c++) begin
      @(posedge pclk);
      #1;
      if (penable_o) n++;
      if (done_o != 2'b00) break;
    end
  endtask

  initial begin
    int n;
    req_i    = '0;
    addr_i   = '0;
    write_i  = '0;
    wdata_i  = '0;
    do_reset();

    chk("rst_psel", {31'd0, psel_o}, 32'd0);
    chk("rst_penable", {31'd0, penable_o}, 32'd0);
    chk("rst_gnt", {30'd0, gnt_o}, 32'd0);
    chk("rst_done", {30'd0, done_o}, 32'd0);
    chk("rst_err", {31'd0, err_o}, 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_paddr", paddr_o, 32'd0);

    // Single zero-wait write from requester 0: psel, penable, done on successive cycles.
    wait_cfg   = 0;
    addr_i[0]  = 32'h10;
    wdata_i[0] = 32'hA5A5_0001;
    write_i[0] = 1'b1;
    issue(2'b01);
    @(posedge pclk); #1;
    chk("w_setup_psel", {31'd0, psel_o}, 32'd1);
    chk("w_setup_penable", {31'd0, penable_o}, 32'd0);
    chk("w_setup_gnt", {30'd0, gnt_o}, 32'd1);
    @(posedge pclk); #1;
    chk("w_access_penable", {31'd0, penable_o}, 32'd1);
    @(posedge pclk); #1;
    chk("w_done", {30'd0, done_o}, 32'd1);
    chk("w_pwdata", pwdata_o, 32'hA5A5_0001);
    wait_idle(20, "write");

    // Read from requester 1 with two wait states.
    wait_cfg   = 2;
    addr_i[1]  = 32'h1234_5678 ^ KEY;
    write_i[1] = 1'b0;
    issue(2'b10);
    count_access(n, 30);
    chk("r_access_cycles", 32'(n), 32'd3);
    chk("r_rdata", rdata_o, 32'h1234_5678);
    wait_idle(20, "read");

    // Address change after grant must not reach the bus.
    wait_cfg   = 1;
    addr_i[0]  = 32'h20;
    write_i[0] = 1'b1;
    wdata_i[0] = 32'hCAFE_0020;
    issue(2'b01);
    @(posedge pclk); #1;
    chk("chg_in_setup", {30'd0, psel_o, penable_o}, 32'b10);
    @(negedge pclk);
    addr_i[0] = 32'h30;
    @(posedge pclk); #1;
    chk("chg_paddr", paddr_o, 32'h20);
    wait_idle(20, "chg");

    // Held contention, then randomized masks and wait states.
    for (int p = 0; p < 4; p++) begin
      wait_cfg = $urandom_range(0, 2);
      rand_payload();
      issue(2'b11);
      wait_idle(60, "contend");
    end
    for (int p = 0; p < 30; p++) begin
      wait_cfg = $urandom_range(0, 3);
      rand_payload();
      issue(2'($urandom_range(1, 3)));
      wait_idle(60, "rand");
    end

    // Reset during ACCESS with the pointer at 1; afterwards requester 0 must win.
    wait_cfg = 0;
    rand_payload();
    issue(2'b01);
    wait_idle(20, "pre_rst");
    wait_cfg = 6;
    req_i    = 2'b10;
    n = 0;
    while (!penable_o && n < 20) begin
      @(posedge pclk); #1;
      n++;
    end
    chk("rst_mid_reached_access", {31'd0, penable_o}, 32'd1);
    @(negedge pclk);
    preset_n = 1'b0;
    req_i    = '0;
    @(negedge pclk);
    preset_n = 1'b1;
    flush_model();
    chk("rst_mid_psel", {31'd0, psel_o}, 32'd0);
    chk("rst_mid_gnt", {30'd0, gnt_o}, 32'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge pclk);
      chk("rst_mid_no_done", {30'd0, done_o}, 32'd0);
    end
    wait_cfg = 0;
    rand_payload();
    issue(2'b11);
    @(posedge pclk); #1;
    chk("rst_mid_regrant", {30'd0, gnt_o}, 32'd1);
    wait_idle(40, "post_rst");

    // Unresponsive slave.
    slave_dead = 1'b1;
    rand_payload();
    write_i[0] = 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
    done_q.push_back('{done: 2'b01, rdata: 32'd0, err: 1'b1});
    mdl_last_rd = '0;
    mdl_ptr     = 1;
    req_i       = 2'b01;
    count_access(n, 100);
    chk("tmo_access_cycles", 32'(n), 32'd16);
    chk("tmo_err", {31'd0, err_o}, 32'd1);
    chk("tmo_rdata", rdata_o, 32'd0);
    wait_idle(20, "tmo");
    slave_dead = 1'b0;
`else
    req_i = 2'b01;
    repeat (40) @(posedge pclk);
    #1;
    chk("stall_psel", {31'd0, psel_o}, 32'd1);
    chk("stall_penable", {31'd0, penable_o}, 32'd1);
    chk("stall_err", {31'd0, err_o}, 32'd0);
    chk("stall_done", {30'd0, done_o}, 32'd0);
    slave_dead = 1'b0;
    do_reset();
`endif

    repeat (3) @(negedge pclk);
    chk("done_q_empty", 32'(done_q.size()), 32'd0);
    chk("apb_q_empty", 32'(apb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, got %0d checks passed of %0d", passes, total);
    $fatal(1, "watchdog");
  end

endmodule
